// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the instruction/data memory arbiter.
//   - arbiter state encoding (RUN / HALTED)
//   - store size codes, same encoding as SaveMethod (SB/SH/SW)
//   - default data burst limit and burst counter width
package mem_arbiter_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } arb_state_e;

    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;

    localparam int MAX_BURST_DEF = 4;
    localparam int BURST_W       = 3;

endpackage

// File: rtl/mem_arb_burst_ctr.sv
// mem_arb_burst_ctr: saturating count of consecutive data grants taken while
// a fetch is waiting, with compare against the burst limit.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clr_i       clear counter (fetch granted, or no fetch waiting)
//   inc_i       data granted while a fetch waits
//   full_o      counter has reached MAX_BURST
module mem_arb_burst_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic full_o
);

    localparam logic [BURST_W-1:0] MAX_B   = BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0] CNT_TOP = '1;

    logic [BURST_W-1:0] cnt_q, cnt_d;

    // Clear wins over increment; increment saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != CNT_TOP))
            cnt_d = cnt_q + BURST_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign full_o = (cnt_q == MAX_B);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between instruction fetch and
// data load/store. Data has priority unless a waiting fetch has already been
// passed over MAX_BURST times in a row. Grants are combinational; read data
// returns one cycle after the grant and is routed to the previous owner.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   if_req, if_addr                 fetch request / PC
//   d_rd, d_wr, d_addr, d_wdata,    data load/store request
//   d_size
//   halt_in, resume_in              halt / resume pulses
//   if_gnt, d_gnt                   grants (this cycle)
//   if_valid/if_rdata,              read responses (cycle after grant)
//   d_valid/d_rdata
//   stall                           fetch waiting but not granted
//   mem_en, mem_we, mem_addr,       memory port
//   mem_wdata, mem_size, mem_rdata
//   err                             sticky: d_rd and d_wr seen together
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N         = 32,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         if_req,
    input  logic [N-1:0] if_addr,
    input  logic         d_rd,
    input  logic         d_wr,
    input  logic [N-1:0] d_addr,
    input  logic [N-1:0] d_wdata,
    input  logic [1:0]   d_size,
    input  logic         halt_in,
    input  logic         resume_in,
    output logic         if_gnt,
    output logic         d_gnt,
    output logic         if_valid,
    output logic         d_valid,
    output logic [N-1:0] if_rdata,
    output logic [N-1:0] d_rdata,
    output logic         stall,
    output logic         mem_en,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic [1:0]   mem_size,
    input  logic [N-1:0] mem_rdata,
    output logic         err
);

    arb_state_e state_q, state_d;
    logic       if_own_q, d_own_q;
    logic       err_q;
    logic       fetch_wait, burst_full, d_any;

    // ---------------- run / halt state ----------------
    // Simultaneous halt and resume leaves the state unchanged.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (halt_in && !resume_in) state_d = ST_HALTED;
            ST_HALTED: if (resume_in && !halt_in) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // ---------------- grant logic ----------------
    assign d_any      = d_rd | d_wr;
    assign fetch_wait = if_req & (state_q == ST_RUN);
    assign d_gnt      = d_any & ~(fetch_wait & burst_full);
    assign if_gnt     = fetch_wait & ~d_gnt;
    assign stall      = if_req & ~if_gnt;
    assign mem_en     = if_gnt | d_gnt;

    mem_arb_burst_ctr #(.MAX_BURST(MAX_BURST)) u_burst (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (if_gnt | ~fetch_wait),
        .inc_i  (d_gnt & fetch_wait),
        .full_o (burst_full)
    );

    // ---------------- memory port mux ----------------
    // d_rd together with d_wr is a store: mem_we follows d_wr.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_size  = SB;
        if (d_gnt) begin
            mem_we    = d_wr;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_size  = d_size;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
            mem_size  = SW;
        end
    end

    // ---------------- response ownership / error ----------------
    // Only reads own a response slot; a store (incl. rd+wr) never returns data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_own_q <= 1'b0;
            d_own_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if_own_q <= if_gnt;
            d_own_q  <= d_gnt & d_rd & ~d_wr;
            if (d_rd && d_wr) err_q <= 1'b1;
        end
    end

    assign if_valid = if_own_q;
    assign d_valid  = d_own_q;
    assign if_rdata = if_own_q ? mem_rdata : '0;
    assign d_rdata  = d_own_q  ? mem_rdata : '0;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_rd, d_wr, halt_in, resume_in;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [1:0]  d_size;
    logic        if_gnt, d_gnt, if_valid, d_valid, stall, mem_en, mem_we, err;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [1:0]  mem_size;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.N(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .halt_in(halt_in), .resume_in(resume_in),
        .if_gnt(if_gnt), .d_gnt(d_gnt), .if_valid(if_valid), .d_valid(d_valid),
        .if_rdata(if_rdata), .d_rdata(d_rdata), .stall(stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_rdata(mem_rdata), .err(err)
    );

    typedef struct {
        logic        if_req, d_rd, d_wr;
        logic [1:0]  d_size;
        logic [31:0] if_addr, d_addr, d_wdata, rdata;
        logic        e_if_gnt, e_d_gnt, e_stall, e_we;
        logic [31:0] e_addr, e_wdata;
        logic [1:0]  e_size;
        logic        e_if_valid, e_d_valid;
        logic [31:0] e_if_rdata, e_d_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        if_req = 0; d_rd = 0; d_wr = 0; halt_in = 0; resume_in = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; d_size = SB; mem_rdata = 0;
    endtask

    initial begin
        // inputs, then expected: if_gnt d_gnt stall we addr wdata size | if_valid d_valid if_rdata d_rdata
        vecs[0] = '{0,0,0,SB, 32'h0,  32'h0,   32'h0,        32'hDEAD0000,
                    0,0,0,0, 32'h0,   32'h0,        SB, 0,0, 32'h0,        32'h0};
        vecs[1] = '{1,0,0,SB, 32'h10, 32'h0,   32'h0,        32'h00500093,
                    1,0,0,0, 32'h10,  32'h0,        SW, 1,0, 32'h00500093, 32'h0};
        vecs[2] = '{1,1,0,SW, 32'h14, 32'h40,  32'h0,        32'hCAFEBABE,
                    0,1,1,0, 32'h40,  32'h0,        SW, 0,1, 32'h0,        32'hCAFEBABE};
        vecs[3] = '{0,0,1,SB, 32'h0,  32'h80,  32'h12345678, 32'h0,
                    0,1,0,1, 32'h80,  32'h12345678, SB, 0,0, 32'h0,        32'h0};
        vecs[4] = '{1,0,1,SH, 32'h20, 32'h84,  32'h0000BEEF, 32'h0,
                    0,1,1,1, 32'h84,  32'h0000BEEF, SH, 0,0, 32'h0,        32'h0};
        vecs[5] = '{1,0,0,SB, 32'h20, 32'h0,   32'h0,        32'h11112222,
                    1,0,0,0, 32'h20,  32'h0,        SW, 1,0, 32'h11112222, 32'h0};
        vecs[6] = '{0,1,0,SW, 32'h0,  32'h100, 32'h0000FFFF, 32'h0BADF00D,
                    0,1,0,0, 32'h100, 32'h0000FFFF, SW, 0,1, 32'h0,        32'h0BADF00D};
        vecs[7] = '{0,0,0,SB, 32'h0,  32'h0,   32'h0,        32'h0,
                    0,0,0,0, 32'h0,   32'h0,        SB, 0,0, 32'h0,        32'h0};

        // ---- reset state ----
        idle();
        rst_n = 0;
        #1;
        chk("rst_if_valid", {31'd0, if_valid}, 0);
        chk("rst_d_valid",  {31'd0, d_valid},  0);
        chk("rst_err",      {31'd0, err},      0);
        chk("rst_mem_en",   {31'd0, mem_en},   0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // ---- table-driven single-cycle transactions ----
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if_req = vecs[i].if_req; d_rd = vecs[i].d_rd; d_wr = vecs[i].d_wr;
            d_size = vecs[i].d_size; if_addr = vecs[i].if_addr; d_addr = vecs[i].d_addr;
            d_wdata = vecs[i].d_wdata; mem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_if_gnt", i),    {31'd0, if_gnt}, {31'd0, vecs[i].e_if_gnt});
            chk($sformatf("v%0d_d_gnt", i),     {31'd0, d_gnt},  {31'd0, vecs[i].e_d_gnt});
            chk($sformatf("v%0d_stall", i),     {31'd0, stall},  {31'd0, vecs[i].e_stall});
            chk($sformatf("v%0d_mem_en", i),    {31'd0, mem_en},
                {31'd0, vecs[i].e_if_gnt | vecs[i].e_d_gnt});
            chk($sformatf("v%0d_mem_we", i),    {31'd0, mem_we}, {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d_mem_addr", i),  mem_addr,  vecs[i].e_addr);
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_mem_size", i),  {30'd0, mem_size}, {30'd0, vecs[i].e_size});
            @(posedge clk); #1;
            chk($sformatf("v%0d_if_valid", i),  {31'd0, if_valid}, {31'd0, vecs[i].e_if_valid});
            chk($sformatf("v%0d_d_valid", i),   {31'd0, d_valid},  {31'd0, vecs[i].e_d_valid});
            if (vecs[i].e_if_valid) chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_if_rdata);
            if (vecs[i].e_d_valid)  chk($sformatf("v%0d_d_rdata", i),  d_rdata,  vecs[i].e_d_rdata);
        end

        // ---- conflict: load wins, fetch granted the following cycle ----
        @(negedge clk); idle();
        @(negedge clk);
        if_req = 1; if_addr = 32'h30; d_rd = 1; d_addr = 32'h40; mem_rdata = 32'h55;
        #1;
        chk("cf_d_gnt",    {31'd0, d_gnt},  1);
        chk("cf_if_gnt",   {31'd0, if_gnt}, 0);
        chk("cf_stall",    {31'd0, stall},  1);
        chk("cf_mem_addr", mem_addr, 32'h40);
        @(negedge clk);
        d_rd = 0;
        #1;
        chk("cf_d_valid",  {31'd0, d_valid}, 1);
        chk("cf_d_rdata",  d_rdata, 32'h55);
        chk("cf_if_gnt2",  {31'd0, if_gnt}, 1);
        chk("cf_stall2",   {31'd0, stall},  0);
        @(posedge clk); #1;
        chk("cf_if_valid", {31'd0, if_valid}, 1);
        chk("cf_d_valid2", {31'd0, d_valid},  0);

        // ---- starvation: 4 stores, 1 fetch, repeating ----
        @(negedge clk); idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if_req = 1; d_wr = 1; if_addr = 32'h50; d_addr = 32'h60;
            #1;
            chk($sformatf("sv%0d_if_gnt", i), {31'd0, if_gnt}, (i % 5 == 4) ? 1 : 0);
            chk($sformatf("sv%0d_d_gnt", i),  {31'd0, d_gnt},  (i % 5 == 4) ? 0 : 1);
        end

        // ---- halt: fetch blocked, data still served; resume re-enables fetch ----
        @(negedge clk); idle(); halt_in = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle(); if_req = 1; if_addr = 32'h70; d_rd = (i == 1); d_addr = 32'h200;
            #1;
            chk($sformatf("h%0d_if_gnt", i), {31'd0, if_gnt}, 0);
            chk($sformatf("h%0d_stall", i),  {31'd0, stall},  1);
            chk($sformatf("h%0d_d_gnt", i),  {31'd0, d_gnt},  (i == 1) ? 1 : 0);
        end
        // halt and resume together while halted: stays halted
        @(negedge clk); d_rd = 0; halt_in = 1; resume_in = 1;
        @(negedge clk); halt_in = 0; resume_in = 0;
        #1;
        chk("h_both_stall", {31'd0, stall}, 1);
        @(negedge clk); resume_in = 1;
        #1;
        chk("h_res_cycle_if_gnt", {31'd0, if_gnt}, 0);
        @(negedge clk); resume_in = 0;
        #1;
        chk("h_after_res_if_gnt", {31'd0, if_gnt}, 1);
        chk("h_after_res_stall",  {31'd0, stall},  0);
        // halt and resume together while running: stays running
        @(negedge clk); halt_in = 1; resume_in = 1;
        @(negedge clk); halt_in = 0; resume_in = 0;
        #1;
        chk("run_both_if_gnt", {31'd0, if_gnt}, 1);

        // ---- error and asynchronous reset ----
        @(negedge clk); idle();
        #1;
        chk("e_err_pre", {31'd0, err}, 0);
        @(negedge clk);
        d_rd = 1; d_wr = 1; d_addr = 32'h300; d_wdata = 32'hA5A5A5A5;
        #1;
        chk("e_mem_we", {31'd0, mem_we}, 1);
        chk("e_d_gnt",  {31'd0, d_gnt},  1);
        @(negedge clk); idle();
        #1;
        chk("e_err",     {31'd0, err},     1);
        chk("e_d_valid", {31'd0, d_valid}, 0);
        @(negedge clk);
        chk("e_err_sticky", {31'd0, err}, 1);
        if_req = 1; if_addr = 32'h40; mem_rdata = 32'h77;
        @(posedge clk); #2;
        chk("e_if_valid_pre", {31'd0, if_valid}, 1);
        rst_n = 0;
        #1;
        chk("e_rst_err",      {31'd0, err},      0);
        chk("e_rst_if_valid", {31'd0, if_valid}, 0);
        chk("e_rst_d_valid",  {31'd0, d_valid},  0);
        idle();
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        chk("e_post_if_valid", {31'd0, if_valid}, 0);
        chk("e_post_d_valid",  {31'd0, d_valid},  0);
        chk("e_post_err",      {31'd0, err},      0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N, default 32: address and data width.
REQ-002 Parameter MAX_BURST, default 4: maximum consecutive data grants while a fetch is waiting.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  instruction fetch request.
REQ-006 if_addr  input  N  fetch address (the PC).
REQ-007 d_rd / d_wr  input  1 each  data load / store request.
REQ-008 d_addr, d_wdata  input  N each  data address and store data.
REQ-009 d_size  input  2  store width (00 byte, 01 half, 10 word), same encoding as SaveMethod.
REQ-010 halt_in / resume_in  input  1 each  single-cycle pulses (ECALL/EBREAK halt, external resume).
REQ-011 if_gnt, d_gnt  output  1 each  combinational grant for the current cycle.
REQ-012 if_valid, d_valid  output  1 each  read data valid; asserted one cycle after the grant.
REQ-013 if_rdata, d_rdata  output  N each  mem_rdata routed to the owner of the previous cycle's grant.
REQ-014 stall  output  1  equals if_req & ~if_gnt; drives loadPC low.
REQ-015 mem_en, mem_we  output  1 each  single-port memory enable and write enable.
REQ-016 mem_addr, mem_wdata  output  N each; mem_size  output  2.
REQ-017 mem_rdata  input  N  memory read data, one cycle after mem_en.
REQ-018 err  output  1  sticky flag, set when d_rd and d_wr are both high.

Function
REQ-019 States: RUN, HALTED.
- RUN -> HALTED on halt_in.
- HALTED -> RUN on resume_in.
- If halt_in and resume_in are asserted together, the state is unchanged.
REQ-020 At most one grant per cycle; mem_en = if_gnt | d_gnt.
REQ-021 Priority: data first. d_gnt = (d_rd|d_wr) & ~(if_req & fetch_ok & burst_cnt==MAX_BURST).
REQ-022 Fetch grant: if_gnt = if_req & fetch_ok & ~d_gnt. fetch_ok = (state==RUN).
REQ-023 burst_cnt is 3-bit and saturating:
- increments on d_gnt while if_req & fetch_ok;
- clears on if_gnt, or on any cycle where no fetch is waiting.
REQ-024 Memory side outputs are combinational from the winning requester.
- Data wins: mem_we = d_wr.
- Fetch wins: mem_we = 0, mem_size = 10.
- No grant: mem_addr = 0, mem_wdata = 0.
REQ-025 A registered owner bit records a fetch grant or a data read grant.
- The following cycle asserts the matching valid and routes mem_rdata to it.
- A store never produces d_valid.
REQ-026 Simultaneous d_rd and d_wr: treated as a store, and err is set until reset.
REQ-027 In HALTED, data requests are still served; fetch is never granted, so stall = if_req.
REQ-028 Latency: request to grant is 0 cycles; grant to valid is 1 cycle. A new grant is allowed every cycle.

Reset
REQ-029 rst_n low immediately (asynchronously) forces:
- state to RUN, burst_cnt to 0, owner/valid registers to 0, err to 0;
- if_valid and d_valid low.
REQ-030 Reset mid-access discards the outstanding response; no valid is asserted after reset release.

Structure
REQ-031 State encoding, size codes (SB/SH/SW) and the MAX_BURST default belong in the shared defines.v.
REQ-032 One sub-module is natural: mem_arb_burst_ctr, the saturating burst counter with compare.

Verification
REQ-033 Fetch only: if_req=1, if_addr=0x10, mem_rdata=0x00500093.
- Required: if_gnt same cycle; if_valid next cycle with if_rdata=0x00500093; stall=0.
REQ-034 Conflict: if_req=1 and d_rd=1 with d_addr=0x40.
- Required: d_gnt=1, stall=1, mem_addr=0x40; next cycle d_valid=1; following cycle if_gnt=1.
REQ-035 Starvation: d_wr held high for 10 cycles while if_req=1, MAX_BURST=4.
- Required: d_gnt for 4 cycles, then if_gnt for 1 cycle, repeating.
REQ-036 Halt: halt_in pulse, then 3 cycles of if_req.
- Required: if_gnt=0 and stall=1 throughout; a d_rd in that window is granted.
- After a resume_in pulse, if_gnt=1 the next cycle.
REQ-037 Error and reset: d_rd=d_wr=1.
- Required: mem_we=1 and err=1.
- Then assert rst_n low mid-cycle: err=0 and if_valid=0 immediately, without waiting for a clock edge.
